// File: rtl/mem_byte_bridge.sv
// mem_byte_bridge: streams words between a byte-wide valid/ready port pair and a word-wide memory.
// Define MEM_BYTE_BRIDGE_CHECKSUM_EN to add an XOR checksum of every byte transferred.
module mem_byte_bridge #(
   parameter int WORD_W     = 32,
   parameter int ADDR_W     = 7,
   parameter int BIG_ENDIAN = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_load,
   input  logic              cmd_dump,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] word_count,
   input  logic [7:0]        byte_in,
   input  logic              byte_in_valid,
   output logic              byte_in_ready,
   output logic [7:0]        byte_out,
   output logic              byte_out_valid,
   input  logic              byte_out_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [WORD_W-1:0] mem_wdata,
   input  logic [WORD_W-1:0] mem_rdata,
   output logic              busy,
`ifdef MEM_BYTE_BRIDGE_CHECKSUM_EN
   output logic              done,
   output logic [7:0]        checksum
`else
   output logic              done
`endif
);

   localparam int NB  = WORD_W / 8;
   localparam int BCW = $clog2(NB + 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_COLLECT,
      LOAD_WRITE,
      DUMP_READ,
      DUMP_LATCH,
      DUMP_SEND,
      DONE
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] count_q;
   logic [WORD_W-1:0] shift_q;
   logic [BCW-1:0]    byteCnt_q;
   logic [WORD_W-1:0] loadShift_d;
   logic [WORD_W-1:0] dumpShift_d;
   logic              lastByte;
   logic              lastWord;

`ifdef MEM_BYTE_BRIDGE_CHECKSUM_EN
   logic [7:0]        csum_q;
   assign checksum = csum_q;
`endif

   // The same shift register assembles load words and serialises dump words, so
   // both directions share one byte order.
   if (BIG_ENDIAN != 0) begin : g_be
      assign loadShift_d = (shift_q << 8) | WORD_W'(byte_in);
      assign dumpShift_d = shift_q << 8;
      assign byte_out    = shift_q[WORD_W-1 -: 8];
   end else begin : g_le
      assign loadShift_d = (shift_q >> 8) | (WORD_W'(byte_in) << (WORD_W - 8));
      assign dumpShift_d = shift_q >> 8;
      assign byte_out    = shift_q[7:0];
   end

   assign lastByte       = (byteCnt_q == BCW'(NB - 1));
   assign lastWord       = (count_q == ADDR_W'(1));
   assign busy           = (state_q != IDLE);
   assign done           = (state_q == DONE);
   assign byte_in_ready  = (state_q == LOAD_COLLECT);
   assign byte_out_valid = (state_q == DUMP_SEND);
   assign mem_we         = (state_q == LOAD_WRITE);
   assign mem_addr       = addr_q;
   assign mem_wdata      = shift_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         count_q   <= '0;
         shift_q   <= '0;
         byteCnt_q <= '0;
`ifdef MEM_BYTE_BRIDGE_CHECKSUM_EN
         csum_q    <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_load || cmd_dump) begin
                  addr_q    <= start_addr;
                  count_q   <= word_count;
                  byteCnt_q <= '0;
`ifdef MEM_BYTE_BRIDGE_CHECKSUM_EN
                  csum_q    <= '0;
`endif
                  if (word_count == '0)
                     state_q <= DONE;
                  else if (cmd_load)
                     state_q <= LOAD_COLLECT;
                  else
                     state_q <= DUMP_READ;
               end
            end
            LOAD_COLLECT: begin
               if (byte_in_valid) begin
                  shift_q <= loadShift_d;
`ifdef MEM_BYTE_BRIDGE_CHECKSUM_EN
                  csum_q  <= csum_q ^ byte_in;
`endif
                  if (lastByte) begin
                     byteCnt_q <= '0;
                     state_q   <= LOAD_WRITE;
                  end else begin
                     byteCnt_q <= byteCnt_q + BCW'(1);
                  end
               end
            end
            LOAD_WRITE: begin
               addr_q  <= addr_q + ADDR_W'(1);
               count_q <= count_q - ADDR_W'(1);
               state_q <= lastWord ? DONE : LOAD_COLLECT;
            end
            DUMP_READ: begin
               state_q <= DUMP_LATCH;
            end
            // Memory returns data the cycle after the address, so latch it here.
            DUMP_LATCH: begin
               shift_q <= mem_rdata;
               state_q <= DUMP_SEND;
            end
            DUMP_SEND: begin
               if (byte_out_ready) begin
                  shift_q <= dumpShift_d;
`ifdef MEM_BYTE_BRIDGE_CHECKSUM_EN
                  csum_q  <= csum_q ^ byte_out;
`endif
                  if (lastByte) begin
                     byteCnt_q <= '0;
                     addr_q    <= addr_q + ADDR_W'(1);
                     count_q   <= count_q - ADDR_W'(1);
                     state_q   <= lastWord ? DONE : DUMP_READ;
                  end else begin
                     byteCnt_q <= byteCnt_q + BCW'(1);
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_byte_bridge.sv
// tb_mem_byte_bridge: directed, table-driven bench for mem_byte_bridge (default 32-bit words, LSB first).
// Checksum checks are compiled in when MEM_BYTE_BRIDGE_CHECKSUM_EN is defined.
module tb_mem_byte_bridge;

   logic        clk;
   logic        rst;
   logic        cmd_load;
   logic        cmd_dump;
   logic [6:0]  start_addr;
   logic [6:0]  word_count;
   logic [7:0]  byte_in;
   logic        byte_in_valid;
   logic        byte_in_ready;
   logic [7:0]  byte_out;
   logic        byte_out_valid;
   logic        byte_out_ready;
   logic [6:0]  mem_addr;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        busy;
   logic        done;
`ifdef MEM_BYTE_BRIDGE_CHECKSUM_EN
   logic [7:0]  checksum;
`endif

   int nCompared   = 0;
   int nMismatched = 0;

   mem_byte_bridge #(.WORD_W(32), .ADDR_W(7), .BIG_ENDIAN(0)) dut (
      .clk            (clk),
      .rst            (rst),
      .cmd_load       (cmd_load),
      .cmd_dump       (cmd_dump),
      .start_addr     (start_addr),
      .word_count     (word_count),
      .byte_in        (byte_in),
      .byte_in_valid  (byte_in_valid),
      .byte_in_ready  (byte_in_ready),
      .byte_out       (byte_out),
      .byte_out_valid (byte_out_valid),
      .byte_out_ready (byte_out_ready),
      .mem_addr       (mem_addr),
      .mem_we         (mem_we),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .busy           (busy),
`ifdef MEM_BYTE_BRIDGE_CHECKSUM_EN
      .done           (done),
      .checksum       (checksum)
`else
      .done           (done)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read memory model: data appears the cycle after the address.
   logic [31:0] mem [128];
   int cyc = 0;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   // Write and output-valid monitor, sampled mid-cycle.
   logic [6:0]  wrAddrLog [256];
   logic [31:0] wrDataLog [256];
   int wrCount       = 0;
   int lastWeCycle   = 0;
   int outValidCount = 0;
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         if (wrCount < 256) begin
            wrAddrLog[wrCount] = mem_addr;
            wrDataLog[wrCount] = mem_wdata;
         end
         wrCount     = wrCount + 1;
         lastWeCycle = cyc;
      end
      if (byte_out_valid === 1'b1) outValidCount = outValidCount + 1;
   end

   typedef struct packed {
      logic        isLoad;
      logic [6:0]  addr;
      logic [6:0]  count;
      logic [2:0]  stall;
      logic [63:0] bytes;
      logic [6:0]  addr0;
      logic [31:0] word0;
      logic [6:0]  addr1;
      logic [31:0] word1;
   } vec_t;

   vec_t vecs [8];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic sendByte(input logic [7:0] b);
      int budget;
      byte_in       = b;
      byte_in_valid = 1'b1;
      budget        = 50;
      while (byte_in_ready !== 1'b1 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (byte_in_ready !== 1'b1) checkOutput("byteInReadyTimeout", 32'(byte_in_ready), 32'd1);
      @(negedge clk);
      byte_in_valid = 1'b0;
   endtask

   task automatic waitDone(output int doneCyc);
      int budget;
      budget = 200;
      while (done !== 1'b1 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (done !== 1'b1) checkOutput("doneTimeout", 32'(done), 32'd1);
      doneCyc = cyc;
   endtask

   task automatic checkPulseEnd();
      @(negedge clk);
      checkOutput("doneOneCycle", 32'(done), 32'd0);
      checkOutput("idleAfterDone", 32'(busy), 32'd0);
   endtask

   task automatic issueCmd(input logic ld, input logic dp, input logic [6:0] a, input logic [6:0] n);
      cmd_load   = ld;
      cmd_dump   = dp;
      start_addr = a;
      word_count = n;
      @(negedge clk);
      cmd_load   = 1'b0;
      cmd_dump   = 1'b0;
   endtask

   task automatic applyStimulus(input int idx, input vec_t v);
      int startWr, doneCyc, nBytes;
      logic [7:0] expByte;
      startWr = wrCount;
      nBytes  = int'(v.count) * 4;
      issueCmd(v.isLoad, !v.isLoad, v.addr, v.count);
      if (v.count == 7'd0) begin
         checkOutput($sformatf("v%0d zeroCountDone", idx), 32'(done), 32'd1);
      end else if (v.isLoad) begin
         checkOutput($sformatf("v%0d firstReady", idx), 32'(byte_in_ready), 32'd1);
      end else begin
         checkOutput($sformatf("v%0d firstMemAddr", idx), 32'(mem_addr), 32'(v.addr));
      end

      if (v.isLoad) begin
         for (int bi = 0; bi < nBytes; bi++) sendByte(v.bytes[63 - 8*bi -: 8]);
         waitDone(doneCyc);
         checkOutput($sformatf("v%0d writeCount", idx), 32'(wrCount - startWr), 32'(v.count));
         if (v.count >= 7'd1) begin
            checkOutput($sformatf("v%0d wr0Addr", idx), 32'(wrAddrLog[startWr]), 32'(v.addr0));
            checkOutput($sformatf("v%0d wr0Data", idx), wrDataLog[startWr], v.word0);
            checkOutput($sformatf("v%0d doneAfterWrite", idx), 32'(doneCyc), 32'(lastWeCycle + 1));
         end
         if (v.count >= 7'd2) begin
            checkOutput($sformatf("v%0d wr1Addr", idx), 32'(wrAddrLog[startWr + 1]), 32'(v.addr1));
            checkOutput($sformatf("v%0d wr1Data", idx), wrDataLog[startWr + 1], v.word1);
         end
      end else begin
         byte_out_ready = 1'b0;
         for (int bi = 0; bi < nBytes; bi++) begin
            int budget;
            expByte = v.bytes[63 - 8*bi -: 8];
            budget  = 50;
            while (byte_out_valid !== 1'b1 && budget > 0) begin
               @(negedge clk);
               budget--;
            end
            if (byte_out_valid !== 1'b1) begin
               checkOutput($sformatf("v%0d outValidTimeout", idx), 32'(byte_out_valid), 32'd1);
               break;
            end
            if (bi == 0) begin
               for (int s = 0; s < int'(v.stall); s++) begin
                  checkOutput($sformatf("v%0d stallByte%0d", idx, s), 32'(byte_out), 32'(expByte));
                  checkOutput($sformatf("v%0d stallValid%0d", idx, s), 32'(byte_out_valid), 32'd1);
                  @(negedge clk);
               end
            end
            checkOutput($sformatf("v%0d outByte%0d", idx, bi), 32'(byte_out), 32'(expByte));
            byte_out_ready = 1'b1;
            @(negedge clk);
            byte_out_ready = 1'b0;
         end
         if (nBytes > 0) checkOutput($sformatf("v%0d dumpDoneNext", idx), 32'(done), 32'd1);
         waitDone(doneCyc);
         checkOutput($sformatf("v%0d dumpNoWrite", idx), 32'(wrCount - startWr), 32'd0);
      end
      checkPulseEnd();
   endtask

   initial begin
      int startWr, startOut, doneCyc;
      rst            = 1'b1;
      cmd_load       = 1'b0;
      cmd_dump       = 1'b0;
      start_addr     = '0;
      word_count     = '0;
      byte_in        = '0;
      byte_in_valid  = 1'b0;
      byte_out_ready = 1'b0;

      //            isLoad addr    count stall stream (send order)          addr0   word0          addr1  word1
      vecs[0] = '{1'b1, 7'd5,   7'd1, 3'd0, 64'h78563412_00000000, 7'd5,   32'h12345678, 7'd0, 32'h0};
      vecs[1] = '{1'b1, 7'd127, 7'd2, 3'd0, 64'h11223344_AABBCCDD, 7'd127, 32'h44332211, 7'd0, 32'hDDCCBBAA};
      vecs[2] = '{1'b0, 7'd5,   7'd1, 3'd3, 64'h78563412_00000000, 7'd0,   32'h0,        7'd0, 32'h0};
      vecs[3] = '{1'b0, 7'd127, 7'd2, 3'd0, 64'h11223344_AABBCCDD, 7'd0,   32'h0,        7'd0, 32'h0};
      vecs[4] = '{1'b1, 7'h10,  7'd1, 3'd0, 64'hEFBEADDE_00000000, 7'h10,  32'hDEADBEEF, 7'd0, 32'h0};
      vecs[5] = '{1'b1, 7'h11,  7'd0, 3'd0, 64'h0,                 7'd0,   32'h0,        7'd0, 32'h0};
      vecs[6] = '{1'b0, 7'h10,  7'd1, 3'd1, 64'hEFBEADDE_00000000, 7'd0,   32'h0,        7'd0, 32'h0};
      vecs[7] = '{1'b0, 7'h12,  7'd0, 3'd0, 64'h0,                 7'd0,   32'h0,        7'd0, 32'h0};

      repeat (3) @(negedge clk);
      checkOutput("rstBusy",         32'(busy),           32'd0);
      checkOutput("rstDone",         32'(done),           32'd0);
      checkOutput("rstMemWe",        32'(mem_we),         32'd0);
      checkOutput("rstByteInReady",  32'(byte_in_ready),  32'd0);
      checkOutput("rstByteOutValid", 32'(byte_out_valid), 32'd0);
      checkOutput("rstByteOut",      32'(byte_out),       32'd0);
      checkOutput("rstMemAddr",      32'(mem_addr),       32'd0);
      checkOutput("rstMemWdata",     mem_wdata,           32'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) applyStimulus(i, vecs[i]);

      // Both commands together: load wins; a dump requested mid-load is ignored.
      startWr  = wrCount;
      startOut = outValidCount;
      issueCmd(1'b1, 1'b1, 7'h20, 7'd1);
      checkOutput("bothCmdReady", 32'(byte_in_ready), 32'd1);
      sendByte(8'h01);
      cmd_dump   = 1'b1;
      start_addr = 7'h40;
      word_count = 7'd1;
      sendByte(8'h02);
      cmd_dump   = 1'b0;
      sendByte(8'h03);
      sendByte(8'h04);
      waitDone(doneCyc);
      checkPulseEnd();
      checkOutput("bothCmdWrites",  32'(wrCount - startWr), 32'd1);
      checkOutput("bothCmdWrAddr",  32'(wrAddrLog[startWr]), 32'h20);
      checkOutput("bothCmdWrData",  wrDataLog[startWr], 32'h04030201);
      checkOutput("bothCmdNoOut",   32'(outValidCount - startOut), 32'd0);

      // Reset after half a word: nothing written, next load assembles cleanly.
      startWr = wrCount;
      issueCmd(1'b1, 1'b0, 7'h30, 7'd1);
      sendByte(8'h11);
      sendByte(8'h22);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("midRstBusy",   32'(busy),          32'd0);
      checkOutput("midRstReady",  32'(byte_in_ready), 32'd0);
      checkOutput("midRstAddr",   32'(mem_addr),      32'd0);
      checkOutput("midRstWdata",  mem_wdata,          32'd0);
      repeat (4) @(negedge clk);
      checkOutput("midRstNoWrite", 32'(wrCount - startWr), 32'd0);
      issueCmd(1'b1, 1'b0, 7'h30, 7'd1);
      sendByte(8'hA1);
      sendByte(8'hB2);
      sendByte(8'hC3);
      sendByte(8'hD4);
      waitDone(doneCyc);
      checkPulseEnd();
      checkOutput("postRstWrites", 32'(wrCount - startWr), 32'd1);
      checkOutput("postRstWrAddr", 32'(wrAddrLog[startWr]), 32'h30);
      checkOutput("postRstWrData", wrDataLog[startWr], 32'hD4C3B2A1);

`ifdef MEM_BYTE_BRIDGE_CHECKSUM_EN
      issueCmd(1'b1, 1'b0, 7'h50, 7'd1);
      sendByte(8'h01);
      sendByte(8'h02);
      sendByte(8'h04);
      sendByte(8'h08);
      waitDone(doneCyc);
      checkOutput("csumLoad", 32'(checksum), 32'h0F);
      checkPulseEnd();
      issueCmd(1'b0, 1'b1, 7'h50, 7'd1);
      byte_out_ready = 1'b1;
      waitDone(doneCyc);
      byte_out_ready = 1'b0;
      checkOutput("csumDump", 32'(checksum), 32'h0F);
      checkPulseEnd();
      issueCmd(1'b1, 1'b0, 7'h51, 7'd0);
      checkOutput("csumZeroDone", 32'(done), 32'd1);
      checkOutput("csumZero", 32'(checksum), 32'h00);
      checkPulseEnd();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] simulation did not complete");
   end

endmodule

// File: doc/mem_byte_bridge.md
MEM_BYTE_BRIDGE -- requirements
Module: mem_byte_bridge

Interface
REQ-001 SHALL have parameter WORD_W, default 32, memory word width in bits (multiple of 8, at least 8).
REQ-002 SHALL have parameter ADDR_W, default 7, memory address width.
REQ-003 SHALL have parameter BIG_ENDIAN, default 0; 0 means LSB byte first, 1 means MSB byte first.
REQ-004 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 cmd_load  in  1  start load (pins to memory); cmd_dump  in  1  start dump (memory to pins).
REQ-007 start_addr  in  ADDR_W  first word address; word_count  in  ADDR_W  words to transfer, sampled with the command.
REQ-008 byte_in  in  8; byte_in_valid  in  1; byte_in_ready  out  1  inbound byte handshake.
REQ-009 byte_out  out  8; byte_out_valid  out  1; byte_out_ready  in  1  outbound byte handshake.
REQ-010 mem_addr  out  ADDR_W; mem_we  out  1; mem_wdata  out  WORD_W; mem_rdata  in  WORD_W, valid one cycle after mem_addr is presented.
REQ-011 busy  out  1  transfer in progress; done  out  1  one-cycle completion pulse.

Function
REQ-012 SHALL implement states IDLE, LOAD_COLLECT, LOAD_WRITE, DUMP_READ, DUMP_LATCH, DUMP_SEND, DONE.
REQ-013 In IDLE, cmd_load SHALL register start_addr/word_count and enter LOAD_COLLECT; cmd_dump SHALL likewise enter DUMP_READ; if both are high, load wins.
REQ-014 Commands SHALL be ignored when not in IDLE.
REQ-015 word_count=0 SHALL go directly to DONE with no memory access and no byte handshake.
REQ-016 byte_in_ready SHALL be high only in LOAD_COLLECT; a byte transfers on a cycle with valid and ready both high.
REQ-017 After WORD_W/8 bytes, SHALL enter LOAD_WRITE and assert mem_we for exactly one cycle with the current address and the assembled word; the first byte goes to bits [7:0] when BIG_ENDIAN=0, else to the top byte.
REQ-018 After each word, address SHALL increment modulo 2^ADDR_W (wrap, no error), and the remaining count SHALL decrement; at zero go to DONE, else LOAD_COLLECT (or DUMP_READ).
REQ-019 DUMP_READ SHALL present mem_addr for one cycle; DUMP_LATCH SHALL capture mem_rdata into the output shift register; DUMP_SEND SHALL then emit bytes in the same order as load.
REQ-020 byte_out_valid SHALL be high only in DUMP_SEND; byte_out SHALL stay stable while valid is high and ready is low.
REQ-021 First inbound ready (or mem_addr presentation) SHALL come one cycle after the accepted command.
REQ-022 DONE SHALL last one cycle with done=1, then IDLE; busy SHALL be 1 in every state except IDLE.
REQ-023 mem_we SHALL never be asserted outside LOAD_WRITE.

Reset
REQ-024 rst SHALL force IDLE and clear the address, count, shift register, and partial-byte counter.
REQ-025 Reset values SHALL be: busy=0, done=0, mem_we=0, byte_in_ready=0, byte_out_valid=0, byte_out=0, mem_addr=0, mem_wdata=0.
REQ-026 Reset mid-transfer SHALL discard any partial word and issue no further write.

Configuration
REQ-027 With MEM_BYTE_BRIDGE_CHECKSUM_EN defined, SHALL add output checksum (8 bits): the XOR of every byte transferred in either direction, cleared on an accepted command and on reset, and valid when done pulses.
REQ-028 Without MEM_BYTE_BRIDGE_CHECKSUM_EN, the checksum port and its logic SHALL be absent.

Verification
REQ-029 Load at addr 5, count 1, bytes 0x78,0x56,0x34,0x12, BIG_ENDIAN=0 -> single mem_we with mem_addr=5, mem_wdata=0x12345678, done one cycle later.
REQ-030 Dump at addr 5 with memory holding 0x12345678, byte_out_ready held low 3 cycles -> byte_out 0x78 stable throughout, then 0x56,0x34,0x12, then done.
REQ-031 Load at addr 127, count 2, ADDR_W=7 -> writes to 127 then 0.
REQ-032 cmd_load and cmd_dump high on the same cycle -> load runs, no byte_out_valid; cmd_dump during busy -> ignored.
REQ-033 rst asserted after 2 of 4 load bytes -> no mem_we, busy=0, and the next load of 4 bytes writes the correct full word.
REQ-034 With the macro, load 0x01,0x02,0x04,0x08 -> checksum=0x0F at done; word_count=0 -> done on the second cycle, checksum=0x00.
